div_goldschmidt: RTL and testbench

DIV_GOLDSCHMIDT -- requirements
Module: div_goldschmidt

---
 rtl/div_goldschmidt_pkg.sv | 37 +++
 rtl/div_goldschmidt_if.sv | 33 +++
 rtl/div_goldschmidt_recip_rom.sv | 36 +++
 rtl/div_goldschmidt.sv | 143 ++++++++++++++
 tb/tb_div_goldschmidt.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/div_goldschmidt_pkg.sv
// ============================================================================
// Module : div_pkg
// Brief  : Shared state encoding and fixed-point helpers for div_goldschmidt.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 24;
    localparam int DEF_ITERS    = 3;
    localparam int DEF_LUT_BITS = 8;
    localparam int DEF_GUARD    = 6;

    // Integer-part constants; scale by the fraction width at the point of use.
    localparam longint unsigned ONE = 64'd1;
    localparam longint unsigned TWO = 64'd2;

    // Internal datapath: 2 integer bits + (WIDTH-1+GUARD) fraction bits.
    function automatic int int_w(input int width, input int guard);
        return width + 1 + guard;
    endfunction

    function automatic int frac_w(input int width, input int guard);
        return width - 1 + guard;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_goldschmidt_if.sv
// ============================================================================
// Module : div_goldschmidt_if
// Brief  : Request/result bundle for the Goldschmidt divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface div_goldschmidt_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] D;
    logic             Sn;
    logic             Sd;
    logic [WIDTH+2:0] Q;
    logic             Sq;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (
        output start, N, D, Sn, Sd,
        input  Q, Sq, busy, done, dz
    );

    modport slave (
        input  start, N, D, Sn, Sd,
        output Q, Sq, busy, done, dz
    );
endinterface

`default_nettype wire

// File: rtl/div_goldschmidt_recip_rom.sv
// ============================================================================
// Module : recip_rom
// Brief  : Combinational seed table of 1/D, indexed by leading fraction bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module recip_rom
    import div_pkg::*;
#(
    parameter int LUT_BITS  = DEF_LUT_BITS,
    parameter int OUT_W     = 31,
    parameter int FRAC_BITS = 29
) (
    input  wire logic [LUT_BITS-1:0] idx,
    output logic      [OUT_W-1:0]    recip
);

    logic [OUT_W-1:0] w_table [2**LUT_BITS];

    // Entry i covers D in [1+i/2^L, 1+(i+1)/2^L); seed is 1/midpoint, rounded.
    for (genvar i = 0; i < 2**LUT_BITS; i++) begin : g_entry
        if (i == 0) begin : g_unit
            assign w_table[i] = OUT_W'(ONE << FRAC_BITS);
        end else begin : g_recip
            localparam longint unsigned C_DEN = (64'd1 << (LUT_BITS + 1)) + 64'(2 * i + 1);
            localparam longint unsigned C_NUM = 64'd1 << (FRAC_BITS + LUT_BITS + 1);
            assign w_table[i] = OUT_W'((2 * C_NUM + C_DEN) / (2 * C_DEN));
        end
    end

    assign recip = w_table[idx];

endmodule

`default_nettype wire

// File: rtl/div_goldschmidt.sv
// ============================================================================
// Module : div_goldschmidt
// Brief  : Iterative Goldschmidt mantissa divider, one iteration per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_goldschmidt
    import div_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ITERS    = DEF_ITERS,
    parameter int LUT_BITS = DEF_LUT_BITS,
    parameter int GUARD    = DEF_GUARD
) (
    input  wire logic         clk,
    input  wire logic         reset,
    div_goldschmidt_if.slave  bus
);

    localparam int IW = int_w(WIDTH, GUARD);
    localparam int FB = frac_w(WIDTH, GUARD);
    localparam int QW = WIDTH + 3;
    localparam int CW = 3;
    localparam logic [IW-1:0] C_TWO = IW'(TWO << FB);

    state_t           r_state;
    logic [WIDTH-1:0] r_n_cap;
    logic [WIDTH-1:0] r_d_cap;
    logic             r_s_cap;
    logic [IW-1:0]    r_rn;
    logic [IW-1:0]    r_rd;
    logic [IW-1:0]    r_k;
    logic [CW-1:0]    r_cnt;
    logic [QW-1:0]    r_q;
    logic             r_sq;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;

    logic [2*IW-1:0]  w_pn;
    logic [2*IW-1:0]  w_pd;
    logic [IW-1:0]    w_rn_next;
    logic [IW-1:0]    w_rd_next;
    logic [IW-1:0]    w_k_next;
    logic [IW-1:0]    w_k0;
    logic             w_unused;

    recip_rom #(
        .LUT_BITS  (LUT_BITS),
        .OUT_W     (IW),
        .FRAC_BITS (FB)
    ) u_rom (
        .idx   (r_d_cap[WIDTH-2 -: LUT_BITS]),
        .recip (w_k0)
    );

    assign w_pn      = {{IW{1'b0}}, r_rn} * {{IW{1'b0}}, r_k};
    assign w_pd      = {{IW{1'b0}}, r_rd} * {{IW{1'b0}}, r_k};
    assign w_rn_next = w_pn[FB +: IW];
    assign w_rd_next = w_pd[FB +: IW];
    assign w_k_next  = C_TWO - w_rd_next;

    // Bits dropped by product truncation and by the final narrowing to Q.
    assign w_unused = ^{w_pn[FB-1:0], w_pn[2*IW-1:FB+IW],
                        w_pd[FB-1:0], w_pd[2*IW-1:FB+IW],
                        r_rn[GUARD-3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_n_cap <= '0;
            r_d_cap <= '0;
            r_s_cap <= 1'b0;
            r_rn    <= '0;
            r_rd    <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sq    <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_n_cap <= bus.N;
                        r_d_cap <= bus.D;
                        r_s_cap <= bus.Sn ^ bus.Sd;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_rn    <= {1'b0, r_n_cap, {GUARD{1'b0}}};
                    r_rd    <= {1'b0, r_d_cap, {GUARD{1'b0}}};
                    r_k     <= w_k0;
                    r_cnt   <= '0;
                    r_state <= ITER;
                end
                ITER: begin
                    r_rn <= w_rn_next;
                    r_rd <= w_rd_next;
                    r_k  <= w_k_next;
                    if (r_cnt == CW'(ITERS - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Publish the finished result; operands captured below belong to the next job.
                    r_done <= 1'b1;
                    r_q    <= r_d_cap[WIDTH-1] ? r_rn[IW-1 -: QW] : {QW{1'b1}};
                    r_sq   <= r_s_cap;
                    r_dz   <= ~r_d_cap[WIDTH-1];
                    if (bus.start) begin
                        r_n_cap <= bus.N;
                        r_d_cap <= bus.D;
                        r_s_cap <= bus.Sn ^ bus.Sd;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Q    = r_q;
    assign bus.Sq   = r_sq;
    assign bus.dz   = r_dz;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_div_goldschmidt.sv
// ============================================================================
// Module : tb_div_goldschmidt
// Brief  : Directed self-checking bench for div_goldschmidt (24/3/8/6).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_div_goldschmidt;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   bc;
    int   cnt;

    logic [23:0] tn [4];
    logic [23:0] td [4];

    div_goldschmidt_if #(.WIDTH(24)) bus ();

    div_goldschmidt #(
        .WIDTH    (24),
        .ITERS    (3),
        .LUT_BITS (8),
        .GUARD    (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact quotient floor(N/D * 2^25)
    function automatic logic [63:0] model_q(input logic [23:0] n, input logic [23:0] d);
        return ({40'd0, n} << 25) / {40'd0, d};
    endfunction

    // Collapses an in-tolerance result onto the model value so check() compares exactly.
    function automatic logic [63:0] tol_obs(input logic [26:0] q, input logic [63:0] e);
        logic [63:0] qq;
        qq = {37'd0, q};
        if (qq + 64'd1 >= e && qq <= e + 64'd1) return e;
        return qq;
    endfunction

    task automatic run_div(input logic [23:0] n, input logic [23:0] d,
                           input logic sn, input logic sd, input bit glitch,
                           output int l, output int b);
        bus.N = n; bus.D = d; bus.Sn = sn; bus.Sd = sd; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        l = 0; b = 0;
        while (bus.done !== 1'b1 && l < 20) begin
            if (bus.busy === 1'b1) b++;
            if (glitch) begin
                bus.start = (l == 2);
                bus.N     = (l == 2) ? 24'hC00000 : n;
                bus.D     = (l == 2) ? 24'h800000 : d;
                bus.Sn    = (l == 2) ? ~sn : sn;
            end
            @(posedge clk); #1;
            l++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        tn = '{24'hFFFFFF, 24'h800000, 24'hABCDEF, 24'h9A0000};
        td = '{24'h800001, 24'hFFFFFF, 24'h912345, 24'hE00001};
        reset = 1'b1;
        bus.start = 1'b0; bus.N = '0; bus.D = '0; bus.Sn = 1'b0; bus.Sd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q",    64'(bus.Q), 64'h0);
        check("rst_flags", 64'({bus.Sq, bus.dz, bus.busy, bus.done}), 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_div(24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, lat, bc);
        check("one_lat",  64'(lat), 64'd5);
        check("one_busy", 64'(bc), 64'd4);
        check("one_q",    64'(bus.Q), 64'h2000000);
        check("one_dz",   64'(bus.dz), 64'h0);
        check("one_sq",   64'(bus.Sq), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 64'(bus.done), 64'h0);
        check("hold_q",    64'(bus.Q), 64'h2000000);

        run_div(24'hC00000, 24'h800000, 1'b1, 1'b0, 1'b0, lat, bc);
        check("c0_q",  64'(bus.Q), 64'h3000000);
        check("c0_sq", 64'(bus.Sq), 64'h1);

        run_div(24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, lat, bc);
        check("third_q",  tol_obs(bus.Q, 64'h1555555), 64'h1555555);
        check("third_sq", 64'(bus.Sq), 64'h0);

        run_div(24'hABCDEF, 24'h800000, 1'b0, 1'b1, 1'b0, lat, bc);
        check("d1_q",  64'(bus.Q), 64'h2AF37BC);
        check("d1_sq", 64'(bus.Sq), 64'h1);

        run_div(24'h400000, 24'h800000, 1'b1, 1'b1, 1'b0, lat, bc);
        check("nsub_q",  64'(bus.Q), 64'h1000000);
        check("nsub_dz", 64'(bus.dz), 64'h0);
        check("nsub_sq", 64'(bus.Sq), 64'h0);

        for (int i = 0; i < 4; i++) begin
            run_div(tn[i], td[i], 1'b0, 1'b0, 1'b0, lat, bc);
            check($sformatf("vec%0d_q", i), tol_obs(bus.Q, model_q(tn[i], td[i])),
                  model_q(tn[i], td[i]));
        end

        run_div(24'h800000, 24'h000000, 1'b0, 1'b0, 1'b0, lat, bc);
        check("dz0_lat", 64'(lat), 64'd5);
        check("dz0_dz",  64'(bus.dz), 64'h1);
        check("dz0_q",   64'(bus.Q), 64'h7FFFFFF);
        run_div(24'hC00000, 24'h400000, 1'b0, 1'b0, 1'b0, lat, bc);
        check("dz4_lat", 64'(lat), 64'd5);
        check("dz4_dz",  64'(bus.dz), 64'h1);
        check("dz4_q",   64'(bus.Q), 64'h7FFFFFF);

        // start re-pulsed mid-operation with different operands must be ignored
        run_div(24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b1, lat, bc);
        check("glitch_lat", 64'(lat), 64'd5);
        check("glitch_q",   tol_obs(bus.Q, 64'h1555555), 64'h1555555);
        check("glitch_sq",  64'(bus.Sq), 64'h0);
        check("glitch_dz",  64'(bus.dz), 64'h0);
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) cnt++;
        end
        check("glitch_extra_done", 64'(cnt), 64'd0);

        // reset during the second ITER cycle
        bus.N = 24'hC00000; bus.D = 24'h800000; bus.Sn = 1'b1; bus.Sd = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_busy", 64'(bus.busy), 64'h0);
        check("mrst_q",    64'(bus.Q), 64'h0);
        check("mrst_done", 64'(bus.done), 64'h0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) cnt++;
        end
        check("mrst_no_done", 64'(cnt), 64'd0);

        // back-to-back: second start sampled while the FSM sits in DONE
        bus.N = 24'h800000; bus.D = 24'h800000; bus.Sn = 1'b0; bus.Sd = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("b2b_pre_done", 64'(bus.done), 64'h0);
        bus.N = 24'hC00000; bus.D = 24'h800000; bus.Sn = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_a_done", 64'(bus.done), 64'h1);
        check("b2b_a_q",    64'(bus.Q), 64'h2000000);
        lat = 0;
        while (bus.done !== 1'b1 || lat == 0) begin
            if (lat >= 20) break;
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_b_lat", 64'(lat), 64'd5);
        check("b2b_b_q",   64'(bus.Q), 64'h3000000);
        check("b2b_b_sq",  64'(bus.Sq), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
